// File: rtl/ppu_pkg.sv
// Shared PPU-side constants and the OAM DMA state encoding.
// Imported by the OAM DMA controller and by the PPU for the OAM address window.
package ppu_pkg;

   localparam logic [15:0] OAM_BASE_ADDR   = 16'hFE00;
   localparam logic [15:0] OAM_END_ADDR    = 16'hFE9F;
   localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
   localparam logic [15:0] HRAM_START_ADDR = 16'hFF80;
   localparam logic [15:0] HRAM_END_ADDR   = 16'hFFFE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } DMA_STATES_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA: an FF46 write copies 160 bytes from {page,00..9F} into OAM, one read + one write per byte.
// Latency: first source read STARTUP_CYCLES+1 cycles after the FF46 write; no backpressure, CPU is blocked outside HRAM.
module oam_dma
   import ppu_pkg::*;
#(
   parameter int OAM_BYTES      = 160,
   parameter int STARTUP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ADDR,
   input  logic        WR,
   input  logic        RD,
   input  logic [7:0]  MMIO_DATA_out,
   output logic [7:0]  MMIO_DATA_in,
   output logic        DMA_ACTIVE,
   output logic        CPU_BUS_BLOCK,
   output logic        DMA_RD,
   output logic [15:0] DMA_ADDR,
   input  logic [7:0]  DMA_DATA_in,
   output logic        OAM_WR,
   output logic [7:0]  OAM_ADDR,
   output logic [7:0]  OAM_DATA
);

   DMA_STATES_t state_q, state_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  ff46_q, ff46_d;
   logic        ff46_wr;
   logic [7:0]  src_eff;
   logic        in_hram;
   logic        unused_rd;

   // Register reads have no wait states, so the read strobe carries no information here.
   assign unused_rd = RD;

   assign ff46_wr = WR && (ADDR == DMA_REG_ADDR);
   // Echo RAM pages E0..FF alias work RAM C0..DF.
   assign src_eff = (ff46_q <= 8'hDF) ? ff46_q : (ff46_q - 8'h20);
   assign in_hram = (ADDR >= HRAM_START_ADDR) && (ADDR <= HRAM_END_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 8'd0;
         cnt_q   <= 8'd0;
         ff46_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ff46_q  <= ff46_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ff46_d  = ff46_wr ? MMIO_DATA_out : ff46_q;
      case (state_q)
         IDLE: ;
         START: begin
            if (cnt_q == 8'(STARTUP_CYCLES - 1)) begin
               state_d = READ;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         READ: state_d = WRITE;
         WRITE: begin
            if (idx_q == 8'(OAM_BYTES - 1)) begin
               state_d = IDLE;
            end else begin
               state_d = READ;
               idx_d   = idx_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A register write starts or restarts the copy from any state; a byte in WRITE still lands this cycle.
      if (ff46_wr) begin
         state_d = START;
         idx_d   = 8'd0;
         cnt_d   = 8'd0;
      end
   end

   always_comb begin
      DMA_RD   = 1'b0;
      DMA_ADDR = 16'h0000;
      OAM_WR   = 1'b0;
      OAM_ADDR = 8'h00;
      OAM_DATA = 8'h00;
      case (state_q)
         READ: begin
            DMA_RD   = 1'b1;
            DMA_ADDR = {src_eff, idx_q};
         end
         WRITE: begin
            OAM_WR   = 1'b1;
            OAM_ADDR = idx_q;
            OAM_DATA = DMA_DATA_in;
         end
         default: ;
      endcase
   end

   assign DMA_ACTIVE    = (state_q != IDLE);
   assign CPU_BUS_BLOCK = DMA_ACTIVE && !in_hram;
   assign MMIO_DATA_in  = (ADDR == DMA_REG_ADDR) ? ff46_q : 8'hFF;

endmodule
